red_pitaya_pid_outlim: RTL and testbench



---
 rtl/red_pitaya_pid_outlim.sv | 134 +++++++++++++
 tb/tb_red_pitaya_pid_outlim.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pid_outlim.sv
// Output conditioning after the PID: clamp to programmable limits, slew-rate limit,
// and rail-dwell detection that issues a timed integrator-reset pulse.
module red_pitaya_pid_outlim #(
  parameter int adc_res = 14,
  parameter int CNT_W   = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic signed [adc_res-1:0] dat_i,
  output logic signed [adc_res-1:0] dat_o,
  input  logic signed [adc_res-1:0] set_lo_i,
  input  logic signed [adc_res-1:0] set_hi_i,
  input  logic        [adc_res-2:0] set_step_i,
  input  logic        [15:0]        set_div_i,
  input  logic        [CNT_W-1:0]   set_rail_cnt_i,
  input  logic        [7:0]         set_rst_len_i,
  output logic                      int_rst_o,
  output logic                      rail_o,
  output logic        [1:0]         state_o
);

  typedef enum logic [1:0] {
    S_TRACK = 2'd0,
    S_RESET = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t                    state;
  logic [15:0]               div_cnt;
  logic [CNT_W-1:0]          rail_cnt;
  logic [CNT_W-1:0]          blank_cnt;
  logic [7:0]                pulse_cnt;

  logic signed [adc_res-1:0] tgt;
  logic signed [adc_res-1:0] dat_nxt;
  logic signed [adc_res:0]   dat_x;
  logic signed [adc_res:0]   diff;
  logic signed [adc_res:0]   step_s;
  logic                      strobe;
  logic                      n_off;
  logic                      rail_hit;
  logic                      blank_done;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tgt = dat_i;
    if (set_lo_i > set_hi_i)    tgt = set_lo_i;
    else if (dat_i > set_hi_i)  tgt = set_hi_i;
    else if (dat_i < set_lo_i)  tgt = set_lo_i;
  end

  // One extra bit of headroom: tgt and dat_o are both in range, so the difference cannot wrap.
  assign dat_x  = $signed({dat_o[adc_res-1], dat_o});
  assign diff   = $signed({tgt[adc_res-1], tgt}) - dat_x;
  assign step_s = $signed({2'b00, set_step_i});
  assign strobe = (div_cnt >= set_div_i);

  always_comb begin
    dat_nxt = tgt;
    if (step_s != '0) begin
      if (diff > step_s)       dat_nxt = adc_res'(dat_x + step_s);
      else if (diff < -step_s) dat_nxt = adc_res'(dat_x - step_s);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      dat_o   <= '0;
      rail_o  <= 1'b0;
    end else begin
      div_cnt <= strobe ? '0 : div_cnt + 16'd1;
      if (strobe) dat_o <= dat_nxt;
      rail_o  <= (dat_i >= set_hi_i) || (dat_i <= set_lo_i);
    end
  end

  // Compare in CNT_W+1 bits so count+1 never wraps at the top of the range.
  assign n_off      = (set_rail_cnt_i == '0);
  assign rail_hit   = ({1'b0, rail_cnt}  + (CNT_W+1)'(1)) >= {1'b0, set_rail_cnt_i};
  assign blank_done = ({1'b0, blank_cnt} + (CNT_W+1)'(1)) >= {1'b0, set_rail_cnt_i};

  // int_rst_o is set alongside each transition so it always equals (next state == RESET).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_TRACK;
      rail_cnt  <= '0;
      pulse_cnt <= '0;
      blank_cnt <= '0;
      int_rst_o <= 1'b0;
    end else begin
      case (state)
        S_TRACK: begin
          if (n_off || !rail_o) begin
            rail_cnt <= '0;
          end else if (rail_hit) begin
            state     <= S_RESET;
            rail_cnt  <= '0;
            pulse_cnt <= '0;
            int_rst_o <= 1'b1;
          end else begin
            rail_cnt <= rail_cnt + CNT_W'(1);
          end
        end
        S_RESET: begin
          if (pulse_cnt >= set_rst_len_i) begin
            state     <= S_BLANK;
            blank_cnt <= '0;
            int_rst_o <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt + 8'd1;
            int_rst_o <= 1'b1;
          end
        end
        S_BLANK: begin
          if (n_off || blank_done) begin
            state    <= S_TRACK;
            rail_cnt <= '0;
          end else begin
            blank_cnt <= blank_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= S_TRACK;
          int_rst_o <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_red_pitaya_pid_outlim.sv
// Scoreboard bench for red_pitaya_pid_outlim: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them.
module tb_red_pitaya_pid_outlim;

  localparam int K_DAT   = 0;
  localparam int K_INT   = 1;
  localparam int K_RAIL  = 2;
  localparam int K_STATE = 3;

  logic               clk_i;
  logic               rst_i;
  logic signed [13:0] dat_i;
  logic signed [13:0] dat_o;
  logic signed [13:0] set_lo_i;
  logic signed [13:0] set_hi_i;
  logic        [12:0] set_step_i;
  logic        [15:0] set_div_i;
  logic        [23:0] set_rail_cnt_i;
  logic        [7:0]  set_rst_len_i;
  logic               int_rst_o;
  logic               rail_o;
  logic        [1:0]  state_o;

  red_pitaya_pid_outlim #(.adc_res(14), .CNT_W(24)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .dat_i          (dat_i),
    .dat_o          (dat_o),
    .set_lo_i       (set_lo_i),
    .set_hi_i       (set_hi_i),
    .set_step_i     (set_step_i),
    .set_div_i      (set_div_i),
    .set_rail_cnt_i (set_rail_cnt_i),
    .set_rst_len_i  (set_rst_len_i),
    .int_rst_o      (int_rst_o),
    .rail_o         (rail_o),
    .state_o        (state_o)
  );

  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  int vin  [8] = '{5000, -8192, 37, 1000, 999, -1000, 37, 0};
  int vout [8] = '{1000, -1000, 37, 1000, 999, -1000, 500, 0};
  int vrail[8] = '{1, 1, 0, 1, 0, 1, 1, 0};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp_v);
    end
  endtask

  function automatic int actual(int kind);
    case (kind)
      K_DAT:   return int'(dat_o);
      K_INT:   return int'(int_rst_o);
      K_RAIL:  return int'(rail_o);
      default: return int'(state_o);
    endcase
  endfunction

  task automatic push(int at, int kind, int val, string name);
    sb.push_back('{cyc: at, kind: kind, val: val, name: name});
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Monitor: compare every expectation due in the current cycle; stale ones count as failures.
  always @(negedge clk_i) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        check({sb[i].name, "_missed"}, sb[i].cyc, cyc);
        sb.delete(i);
      end else if (sb[i].cyc == cyc) begin
        check(sb[i].name, actual(sb[i].kind), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    int t;
    rst_i          = 1'b1;
    dat_i          = '0;
    set_lo_i       = 14'(-1000);
    set_hi_i       = 14'(1000);
    set_step_i     = '0;
    set_div_i      = '0;
    set_rail_cnt_i = '0;
    set_rst_len_i  = 8'd4;

    tick(3);
    push(cyc, K_DAT,   0, "rst_dat");
    push(cyc, K_INT,   0, "rst_int");
    push(cyc, K_RAIL,  0, "rst_rail");
    push(cyc, K_STATE, 0, "rst_state");
    dat_i = 14'(5000);
    tick();
    rst_i = 1'b0;

    // Clamp, rail flag boundaries, and inverted limits.
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        set_lo_i = 14'(500);
        set_hi_i = 14'(-500);
      end else begin
        set_lo_i = 14'(-1000);
        set_hi_i = 14'(1000);
      end
      dat_i = 14'(vin[i]);
      push(cyc + 1, K_DAT,  vout[i],  "clamp_dat");
      push(cyc + 1, K_RAIL, vrail[i], "clamp_rail");
      tick();
    end

    // Slew: step 100, one update every 4 cycles.
    t = cyc;
    set_div_i  = 16'd3;
    set_step_i = 13'(100);
    dat_i      = 14'(350);
    push(t + 3,  K_DAT, 0,   "slew_hold0");
    push(t + 4,  K_DAT, 100, "slew_up1");
    push(t + 7,  K_DAT, 100, "slew_hold1");
    push(t + 8,  K_DAT, 200, "slew_up2");
    push(t + 12, K_DAT, 300, "slew_up3");
    push(t + 16, K_DAT, 350, "slew_up4");
    push(t + 19, K_DAT, 350, "slew_hold4");
    push(t + 20, K_DAT, 250, "slew_dn1");
    push(t + 24, K_DAT, 150, "slew_dn2");
    push(t + 28, K_DAT, 50,  "slew_dn3");
    push(t + 32, K_DAT, -50, "slew_dn4");
    push(t + 33, K_DAT, -50, "slew_hold_dn");
    push(t + 35, K_DAT, 200, "div_lowered");
    tick(16);
    dat_i = 14'(-50);
    tick(18);
    // div_cnt is 2 here; dropping div to 1 must strobe on the next edge.
    set_div_i  = 16'd1;
    set_step_i = '0;
    dat_i      = 14'(200);
    tick();

    // Rail dwell: N=10, L=4.
    t = cyc;
    set_div_i      = '0;
    set_rail_cnt_i = 24'd10;
    set_rst_len_i  = 8'd4;
    dat_i          = 14'(1000);
    push(t,     K_RAIL, 0,    "dwell_rail_pre");
    push(t + 1, K_RAIL, 1,    "dwell_rail_rise");
    push(t + 1, K_DAT,  1000, "dwell_dat");
    for (int j = 0; j < 28; j++) begin
      push(t + j, K_INT, (j >= 11 && j <= 15) ? 1 : 0, "dwell_int");
      push(t + j, K_STATE, (j <= 10) ? 0 : (j <= 15) ? 1 : (j <= 25) ? 2 : 0, "dwell_state");
    end
    tick(20);
    dat_i = '0;
    tick(8);

    // Interrupted dwell: 9 rail cycles, 1 off, 9 rail -> no pulse.
    t = cyc;
    for (int j = 0; j < 26; j++) begin
      push(t + j, K_INT,   0, "intr_int");
      push(t + j, K_STATE, 0, "intr_state");
    end
    push(t + 9,  K_RAIL, 1, "intr_rail_on");
    push(t + 10, K_RAIL, 0, "intr_rail_gap");
    dat_i = 14'(1000);
    tick(9);
    dat_i = '0;
    tick();
    dat_i = 14'(1000);
    tick(9);
    dat_i = '0;
    tick(7);

    // Lowering N below rail_cnt while at rail enters RESET on the next cycle.
    t = cyc;
    for (int j = 0; j < 17; j++) begin
      push(t + j, K_INT, (j >= 7 && j <= 11) ? 1 : 0, "thr_int");
      push(t + j, K_STATE, (j <= 6) ? 0 : (j <= 11) ? 1 : (j <= 14) ? 2 : 0, "thr_state");
    end
    dat_i = 14'(1000);
    tick(6);
    set_rail_cnt_i = 24'd3;
    tick(4);
    dat_i = '0;
    tick(7);

    // Detection off: pinned at the lower rail for 1000 cycles.
    t = cyc;
    set_rail_cnt_i = '0;
    dat_i          = 14'(-1000);
    for (int j = 1; j < 1000; j++) begin
      push(t + j, K_INT,   0, "off_int");
      push(t + j, K_STATE, 0, "off_state");
      push(t + j, K_RAIL,  1, "off_rail");
    end
    push(t + 999, K_DAT, -1000, "off_dat");
    tick(1000);
    dat_i = '0;
    tick(2);

    // Asynchronous reset during the third pulse cycle, then a full fresh dwell.
    t = cyc;
    set_rail_cnt_i = 24'd10;
    set_rst_len_i  = 8'd4;
    dat_i          = 14'(1000);
    push(t + 11, K_INT,   1, "mid_int_p1");
    push(t + 12, K_INT,   1, "mid_int_p2");
    push(t + 12, K_STATE, 1, "mid_state_p2");
    push(t + 13, K_INT,   0, "mid_rst_int");
    push(t + 13, K_DAT,   0, "mid_rst_dat");
    push(t + 13, K_STATE, 0, "mid_rst_state");
    push(t + 13, K_RAIL,  0, "mid_rst_rail");
    push(t + 14, K_DAT,   0, "mid_rst_dat_hold");
    push(t + 15, K_RAIL,  1, "mid_rail_again");
    push(t + 15, K_DAT,   1000, "mid_dat_again");
    for (int j = 14; j <= 30; j++)
      push(t + j, K_INT, (j >= 25 && j <= 29) ? 1 : 0, "mid_redwell_int");
    push(t + 24, K_STATE, 0, "mid_redwell_track");
    push(t + 25, K_STATE, 1, "mid_redwell_reset");
    tick(13);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick(17);

    for (int w = 0; w < 50 && sb.size() > 0; w++) tick();
    while (sb.size() > 0) begin
      bad++;
      total++;
      $display("FAIL %s timeout: due cyc=%0d never compared, expected=%0d", sb[0].name, sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
